// File: rtl/lottery.sv
// Lottery ticket reader: scans a line count, then 4 ascending numbers per line, and accumulates a BCD prize.
// One register stage per scan edge; rejected values hold the read position and raise RD_ERR until the next accepted value.
module lottery (
    input  logic       scan,
    input  logic       reset,
    input  logic [4:0] W1,
    input  logic [4:0] W2,
    input  logic [4:0] W3,
    input  logic [4:0] W4,
    input  logic [4:0] N_in,
    output logic       SYSRDY,
    output logic       winner,
    output logic       not_a_win,
    output logic       RD_ERR,
    output logic [2:0] Eur100,
    output logic [3:0] Eur010,
    output logic [3:0] Eur001
);

    typedef enum logic [1:0] {
        COUNT   = 2'd0,
        NUMBERS = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [2:0] line_cnt;
    logic [1:0] pos;
    logic [2:0] match;
    logic [4:0] prev;
    logic [2:0] hund;
    logic [3:0] tens;
    logic [3:0] units;
    logic       rd_err;

    logic       count_ok;
    logic       num_ok;
    logic       hit;
    logic       last_num;
    logic       last_line;
    logic [2:0] match_new;
    logic       add_h;
    logic       add_t;
    logic       add_u;
    logic [4:0] u_sum;
    logic [4:0] u_fix;
    logic       carry_u;
    logic [4:0] t_sum;
    logic [4:0] t_fix;
    logic       carry_t;
    logic [2:0] hund_new;
    logic [3:0] tens_new;
    logic [3:0] units_new;
    logic       total_nz;

    // Input qualification
    always_comb begin
        count_ok  = (N_in >= 5'd1) && (N_in <= 5'd4);
        num_ok    = (N_in != 5'd0) && ((pos == 2'd0) || (N_in > prev));
        hit       = (N_in == W1) || (N_in == W2) || (N_in == W3) || (N_in == W4);
        last_num  = (pos == 2'd3);
        last_line = (line_cnt == 3'd1);
        match_new = match + {2'b00, hit};
    end

    // Line prize selection and BCD accumulation with per-digit carry
    always_comb begin
        add_h = (match_new == 3'd4);
        add_t = (match_new == 3'd3);
        add_u = (match_new == 3'd2);

        u_sum   = {1'b0, units} + {4'b0000, add_u};
        carry_u = (u_sum > 5'd9);
        u_fix   = carry_u ? (u_sum - 5'd10) : u_sum;

        t_sum   = {1'b0, tens} + {4'b0000, add_t} + {4'b0000, carry_u};
        carry_t = (t_sum > 5'd9);
        t_fix   = carry_t ? (t_sum - 5'd10) : t_sum;

        units_new = u_fix[3:0];
        tens_new  = t_fix[3:0];
        hund_new  = hund + {2'b00, add_h} + {2'b00, carry_t};
    end

    // State register
    always_ff @(posedge scan or posedge reset) begin
        if (reset) begin
            state <= COUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = COUNT;
        case (state)
            COUNT, DONE: begin
                state_nxt = count_ok ? NUMBERS : COUNT;
            end
            NUMBERS: begin
                if (num_ok && last_num && last_line) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = NUMBERS;
                end
            end
            default: state_nxt = COUNT;
        endcase
    end

    // Ticket datapath: counters, previous number, running total, error flag
    always_ff @(posedge scan or posedge reset) begin
        if (reset) begin
            line_cnt <= 3'd0;
            pos      <= 2'd0;
            match    <= 3'd0;
            prev     <= 5'd0;
            hund     <= 3'd0;
            tens     <= 4'd0;
            units    <= 4'd0;
            rd_err   <= 1'b0;
        end else begin
            case (state)
                COUNT, DONE: begin
                    pos   <= 2'd0;
                    match <= 3'd0;
                    prev  <= 5'd0;
                    hund  <= 3'd0;
                    tens  <= 4'd0;
                    units <= 4'd0;
                    if (count_ok) begin
                        line_cnt <= N_in[2:0];
                        rd_err   <= 1'b0;
                    end else begin
                        rd_err   <= 1'b1;
                    end
                end
                NUMBERS: begin
                    if (!num_ok) begin
                        rd_err <= 1'b1;
                    end else begin
                        rd_err <= 1'b0;
                        prev   <= N_in;
                        if (last_num) begin
                            hund     <= hund_new;
                            tens     <= tens_new;
                            units    <= units_new;
                            match    <= 3'd0;
                            pos      <= 2'd0;
                            line_cnt <= line_cnt - 3'd1;
                        end else begin
                            match <= match_new;
                            pos   <= pos + 2'd1;
                        end
                    end
                end
                default: begin
                    rd_err <= 1'b0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        total_nz  = (hund != 3'd0) || (tens != 4'd0) || (units != 4'd0);
        SYSRDY    = (state == COUNT);
        winner    = (state == DONE) && total_nz;
        not_a_win = (state == DONE) && !total_nz;
        RD_ERR    = rd_err;
        Eur100    = hund;
        Eur010    = tens;
        Eur001    = units;
    end

endmodule

// File: tb/tb_lottery.sv
// Directed bench for the lottery reader: each step drives N_in, pulses scan, and checks the packed output vector.
module tb_lottery;

    logic       scan;
    logic       reset;
    logic [4:0] W1, W2, W3, W4;
    logic [4:0] N_in;
    logic       SYSRDY, winner, not_a_win, RD_ERR;
    logic [2:0] Eur100;
    logic [3:0] Eur010, Eur001;

    int tests  = 0;
    int failed = 0;

    lottery dut (
        .scan      (scan),
        .reset     (reset),
        .W1        (W1),
        .W2        (W2),
        .W3        (W3),
        .W4        (W4),
        .N_in      (N_in),
        .SYSRDY    (SYSRDY),
        .winner    (winner),
        .not_a_win (not_a_win),
        .RD_ERR    (RD_ERR),
        .Eur100    (Eur100),
        .Eur010    (Eur010),
        .Eur001    (Eur001)
    );

    logic [14:0] outs;
    assign outs = {SYSRDY, winner, not_a_win, RD_ERR, Eur100, Eur010, Eur001};

    function automatic logic [14:0] ex(input logic s, input logic w, input logic n,
                                       input logic e, input logic [2:0] h,
                                       input logic [3:0] t, input logic [3:0] u);
        return {s, w, n, e, h, t, u};
    endfunction

    task automatic do_scan(input logic [4:0] v);
        N_in = v;
        #5 scan = 1'b1;
        #5 scan = 1'b0;
        #1;
    endtask

    task automatic chk(input string tag, input logic [14:0] exp);
        tests++;
        assert (outs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
        end
    endtask

    task automatic scan_line(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d);
        do_scan(a);
        do_scan(b);
        do_scan(c);
        do_scan(d);
    endtask

    initial begin
        scan  = 1'b0;
        reset = 1'b1;
        N_in  = 5'd0;
        W1 = 5'd4; W2 = 5'd21; W3 = 5'd22; W4 = 5'd30;
        #7;
        chk("reset_state", ex(1, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        reset = 1'b0;
        #3;

        // No-match ticket
        do_scan(5'd1);
        chk("count1_accept", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd5);
        do_scan(5'd20);
        do_scan(5'd24);
        chk("nomatch_not_done", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd28);
        chk("nomatch_done", ex(0, 0, 1, 0, 3'd0, 4'd0, 4'd0));

        // Jackpot line
        do_scan(5'd1);
        chk("done_newcount", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        chk("four_match_100", ex(0, 1, 0, 0, 3'd1, 4'd0, 4'd0));

        // Two lines: 1 match then 3 matches
        do_scan(5'd2);
        scan_line(5'd1, 5'd3, 5'd22, 5'd26);
        chk("line1_one_match", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        scan_line(5'd4, 5'd21, 5'd22, 5'd29);
        chk("three_match_010", ex(0, 1, 0, 0, 3'd0, 4'd1, 4'd0));

        // Error recovery
        do_scan(5'd5);
        chk("bad_count", ex(1, 0, 0, 1, 3'd0, 4'd0, 4'd0));
        do_scan(5'd0);
        chk("zero_count", ex(1, 0, 0, 1, 3'd0, 4'd0, 4'd0));
        do_scan(5'd1);
        chk("good_count_clears_err", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd10);
        chk("first_num_accept", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd10);
        chk("not_ascending", ex(0, 0, 0, 1, 3'd0, 4'd0, 4'd0));
        do_scan(5'd0);
        chk("zero_number", ex(0, 0, 0, 1, 3'd0, 4'd0, 4'd0));
        do_scan(5'd12);
        chk("accept_clears_err", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd13);
        chk("third_num_not_done", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd14);
        chk("err_ticket_done", ex(0, 0, 1, 0, 3'd0, 4'd0, 4'd0));

        // Four jackpot lines -> 400, with running totals
        do_scan(5'd4);
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        chk("running_200", ex(0, 0, 0, 0, 3'd2, 4'd0, 4'd0));
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        chk("max_400", ex(0, 1, 0, 0, 3'd4, 4'd0, 4'd0));
        do_scan(5'd2);
        chk("newcount_clears_400", ex(0, 0, 0, 0, 3'd0, 4'd0, 4'd0));

        // Mixed prizes 100 + 10 + 1 + 0 = 111 (fresh 4-line ticket after reset)
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #2;
        do_scan(5'd4);
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        scan_line(5'd4, 5'd21, 5'd22, 5'd31);
        scan_line(5'd4, 5'd21, 5'd23, 5'd24);
        chk("running_111", ex(0, 0, 0, 0, 3'd1, 4'd1, 4'd1));
        scan_line(5'd1, 5'd2, 5'd3, 5'd5);
        chk("mixed_111", ex(0, 1, 0, 0, 3'd1, 4'd1, 4'd1));

        // Reset mid-ticket, async and discarding partial state
        do_scan(5'd1);
        do_scan(5'd4);
        do_scan(5'd21);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", ex(1, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        do_scan(5'd1);
        chk("scan_ignored_in_reset", ex(1, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        reset = 1'b0;
        #2;
        do_scan(5'd1);
        scan_line(5'd4, 5'd21, 5'd22, 5'd30);
        chk("after_reset_fresh", ex(0, 1, 0, 0, 3'd1, 4'd0, 4'd0));

        // Reset while in DONE clears winner immediately
        reset = 1'b1;
        #1;
        chk("reset_in_done", ex(1, 0, 0, 0, 3'd0, 4'd0, 4'd0));
        reset = 1'b0;
        #2;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lottery.md
LOTTERY -- requirements
Module: lottery

Interface
REQ-001 The block SHALL use one clock, scan, and an asynchronous active-high reset, reset; every register SHALL update only on the rising edge of scan, except that reset clears registers immediately.
REQ-002 scan  input  1  clock and read strobe; each rising edge samples N_in once.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 W1, W2, W3, W4  input  5 each  winning numbers, held stable while a ticket is read, compared by equality only.
REQ-005 N_in  input  5  scanned value: a line count in the COUNT phase, a ticket number in the NUMBERS phase.
REQ-006 SYSRDY  output  1  high while the block is waiting for a line count.
REQ-007 winner  output  1  high in DONE when total prize > 0.
REQ-008 not_a_win  output  1  high in DONE when total prize = 0.
REQ-009 RD_ERR  output  1  high after the last scanned value was rejected.
REQ-010 Eur100  output  3  hundreds BCD digit of total prize, range 0-4.
REQ-011 Eur010, Eur001  output  4 each  tens and units BCD digits, range 0-9.

Function
REQ-012 The block SHALL have three states: COUNT (SYSRDY=1), NUMBERS and DONE.
REQ-013 In COUNT or DONE, a scan edge with N_in in 1..4 SHALL perform all of the following on that edge:
- load the line counter with N_in;
- clear the position index, the match count, the total prize and RD_ERR;
- deassert winner and not_a_win;
- enter NUMBERS.
REQ-014 In COUNT or DONE, a scan edge with N_in = 0 or N_in > 4 SHALL set RD_ERR=1, enter COUNT and clear the prize outputs and winner/not_a_win.
REQ-015 In NUMBERS, each line SHALL consist of 4 numbers; a number SHALL be accepted only if it is in 1..31 and strictly greater than the previously accepted number of the same line (no check for the first number).
REQ-016 A rejected number SHALL set RD_ERR=1, leave the position index unchanged and leave the match count unchanged; the next scan SHALL re-read the same position.
REQ-017 Any accepted value SHALL clear RD_ERR on the same edge.
REQ-018 An accepted number equal to any of W1..W4 SHALL increment the line match count (0..4).
REQ-019 On acceptance of the 4th number of a line, the line prize SHALL be added to the total in BCD, with per-digit carry, on the same edge:
- 4 matches: 100;
- 3 matches: 10;
- 2 matches: 1;
- fewer than 2 matches: 0.
REQ-020 After the addition in REQ-019, the match count and the position index SHALL be cleared and the line counter decremented.
REQ-021 The maximum total SHALL be 400, so Eur100 never overflows.
REQ-022 When the last line completes, the block SHALL enter DONE on that same edge, with outputs valid after that edge.
REQ-023 In DONE: winner = (total != 0) and not_a_win = (total == 0).
REQ-024 Outside DONE, winner and not_a_win SHALL both be 0.
REQ-025 Eur100/Eur010/Eur001 SHALL hold the running total in NUMBERS and the final total in DONE until the next valid line count or reset.
REQ-026 SYSRDY SHALL be 1 exactly in COUNT.

Reset
REQ-027 Assertion of reset SHALL force all of the following immediately, regardless of scan:
- state COUNT, SYSRDY=1;
- winner=0, not_a_win=0, RD_ERR=0;
- Eur100=0, Eur010=0, Eur001=0;
- line counter, position index and match count = 0.
REQ-028 Reset asserted mid-ticket SHALL discard the partial ticket; scan edges while reset is high SHALL be ignored.

Verification
REQ-029 W=4,21,22,30; scan 1, then 5,20,24,28 -> after the 5th edge DONE, not_a_win=1, winner=0, Euro 0 0 0, RD_ERR=0 throughout.
REQ-030 W=4,21,22,30; scan 1, then 4,21,22,30 -> winner=1, Euro 1 0 0.
REQ-031 W=4,21,22,30; scan 2, then line 1,3,22,26 (1 match) and line 4,21,22,29 (3 matches) -> winner=1, Euro 0 1 0.
REQ-032 Error recovery -> required responses:
- scan count 5 -> RD_ERR=1, SYSRDY=1;
- scan count 1 -> RD_ERR=0;
- scan 10 -> accepted;
- scan 10 -> RD_ERR=1 (not ascending);
- scan 0 -> RD_ERR=1;
- scan 12,13,14 -> accepted, RD_ERR=0, DONE reached only after 4 accepted numbers.
REQ-033 Scan count 4, all lines 4,21,22,30 -> Euro 4 0 0; a new count scan in DONE clears the outputs to 0 and winner to 0.
REQ-034 Reset pulse after 2 accepted numbers -> SYSRDY=1 and all outputs 0 immediately, without a scan edge.
